uart_reset_sequencer: RTL

Avalon-MM slave that sequences the UART reset lines rather than having software toggle them directly through a PIO. On a start command it asserts all N_RST active-high reset lines, holds them for a programmable time, then releases them one at a time, lowest index first, with a programmable gap between releases. A manual override mode gives software direct bit control for debug. It sits on the same Avalon bus segment as the UART and drives that UART's reset inputs.

---
 rtl/uart_rst_seq_pkg.sv | 29 ++
 rtl/uart_rst_seq_timer.sv | 27 ++
 rtl/uart_reset_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rst_seq_pkg.sv
// Shared definitions for the UART reset sequencer: register addresses,
// register field bit positions, and the sequencer FSM state encoding.
// Imported by uart_reset_sequencer; the timer has no dependency on it.
package uart_rst_seq_pkg;

  // Word addresses on the Avalon-MM slave
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_HOLD   = 2'd2;
  localparam logic [1:0] ADDR_GAP    = 2'd3;

  // CTRL fields
  localparam int START          = 0;
  localparam int MANUAL_EN      = 1;
  localparam int MANUAL_VAL_LSB = 2;
  localparam int IRQ_EN         = 7;

  // STATUS fields (bit0 is busy)
  localparam int DONE    = 1;
  localparam int OUT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    DN      = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rst_seq_timer.sv
// Loadable down counter used for the hold and gap intervals.
// Ports: clk/reset, load + load_val (load has priority), value, zero flag.
// Counts down by one per cycle and parks at zero until reloaded.
module uart_rst_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/uart_reset_sequencer.sv
// Avalon-MM slave that asserts N_RST UART reset lines, holds them for HOLD
// cycles, then releases them lowest index first with GAP cycles between.
// Ports: clk, reset, address/chipselect/write_n/writedata/readdata (slave),
// out_port (1 = in reset), busy; irq only when UART_RST_SEQ_IRQ_EN is defined.
module uart_reset_sequencer
  import uart_rst_seq_pkg::*;
#(
  parameter int N_RST     = 3,
  parameter int CNT_W     = 16,
  parameter int HOLD_INIT = 16,
  parameter int GAP_INIT  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [N_RST-1:0] out_port,
  output logic             busy
`ifdef UART_RST_SEQ_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int IDX_W = (N_RST > 1) ? $clog2(N_RST) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [N_RST-1:0]   out_nxt;
  logic               busy_nxt;
  logic               done, done_nxt, done_set;
  logic               manual_en, manual_en_nxt;
  logic [N_RST-1:0]   manual_val, manual_val_nxt;
  logic [CNT_W-1:0]   hold, gap, hold_m1, gap_m1;
  logic               tmr_load, tmr_zero;
  logic [CNT_W-1:0]   tmr_val, tmr_value;
  logic               wr, wr_ctrl, wr_status, start;
  logic               unused_sig;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == ADDR_CTRL);
  assign wr_status = wr && (address == ADDR_STATUS);

  // Zero intervals behave as one cycle
  assign hold_m1 = (hold == '0) ? '0 : hold - CNT_W'(1);
  assign gap_m1  = (gap  == '0) ? '0 : gap  - CNT_W'(1);

  // Manual mode takes effect from the write itself, so decisions in the
  // same cycle use the post-write value.
  assign manual_en_nxt  = wr_ctrl ? writedata[MANUAL_EN] : manual_en;
  assign manual_val_nxt = wr_ctrl ? writedata[MANUAL_VAL_LSB +: N_RST] : manual_val;
  assign start          = wr_ctrl & writedata[START] & ~manual_en_nxt;

  assign unused_sig = ^{writedata, tmr_value};

  uart_rst_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    out_nxt   = out_port;
    busy_nxt  = busy;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ASSERT;
          out_nxt   = '1;
          busy_nxt  = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = hold_m1;
        end
      end
      ASSERT: begin
        if (tmr_zero) begin
          out_nxt[0] = 1'b0;
          if (N_RST == 1) begin
            state_nxt = DN;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = RELEASE;
            idx_nxt   = IDX_W'(1);
            tmr_load  = 1'b1;
            tmr_val   = gap_m1;
          end
        end
      end
      RELEASE: begin
        if (tmr_zero) begin
          out_nxt[idx] = 1'b0;
          if (idx == IDX_W'(N_RST - 1)) begin
            state_nxt = DN;
            busy_nxt  = 1'b0;
          end else begin
            idx_nxt  = idx + IDX_W'(1);
            tmr_load = 1'b1;
            tmr_val  = gap_m1;
          end
        end
      end
      default: begin  // DN: single cycle, flag completion
        done_set  = 1'b1;
        state_nxt = IDLE;
      end
    endcase
    // Manual mode overrides the lines and aborts any sequence without
    // flagging completion.
    if (manual_en_nxt) begin
      out_nxt = manual_val_nxt;
      if (state != IDLE) begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_set  = 1'b0;
        tmr_load  = 1'b0;
      end
    end
  end

  // Completion set takes priority over a simultaneous software clear
  assign done_nxt = done_set ? 1'b1 :
                    (wr_status && writedata[DONE]) ? 1'b0 : done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      out_port   <= '1;
      busy       <= 1'b0;
      done       <= 1'b0;
      manual_en  <= 1'b0;
      manual_val <= '1;
      hold       <= CNT_W'(HOLD_INIT);
      gap        <= CNT_W'(GAP_INIT);
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      out_port   <= out_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      manual_en  <= manual_en_nxt;
      manual_val <= manual_val_nxt;
      if (wr && address == ADDR_HOLD) hold <= writedata[CNT_W-1:0];
      if (wr && address == ADDR_GAP)  gap  <= writedata[CNT_W-1:0];
    end
  end

`ifdef UART_RST_SEQ_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= writedata[IRQ_EN];
      irq <= done & irq_en;
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[MANUAL_EN]                = manual_en;
        readdata[MANUAL_VAL_LSB +: N_RST]  = manual_val;
`ifdef UART_RST_SEQ_IRQ_EN
        readdata[IRQ_EN]                   = irq_en;
`endif
      end
      ADDR_STATUS: begin
        readdata[0]                = busy;
        readdata[DONE]             = done;
        readdata[OUT_LSB +: N_RST] = out_port;
      end
      ADDR_HOLD: readdata[CNT_W-1:0] = hold;
      default:   readdata[CNT_W-1:0] = gap;
    endcase
  end

endmodule
